// File: rtl/eq_tap_pkg.sv
// Shared types, default widths and coefficient helpers for the equalizer tap generator.
package eq_tap_pkg;

  localparam int DEF_NUM_BANDS = 4;
  localparam int DEF_GAIN_W    = 2;
  localparam int DEF_NUM_TAPS  = 16;
  localparam int DEF_COEFF_W   = 16;
  localparam int BASE_W        = 32;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT, DONE} state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Bring-up table: every band contributes tap+1; the production table drops in here.
  function automatic logic signed [BASE_W-1:0] base_coeff(input int band, input int tap);
    if (band < 0 || tap < 0) return '0;
    return tap + 1;
  endfunction

endpackage

// File: rtl/eq_band_rom.sv
// Combinational (band, tap) -> base coefficient lookup; kept separate so it can become a BRAM.
module eq_band_rom
  import eq_tap_pkg::*;
#(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int COEFF_W   = DEF_COEFF_W
) (
  input  logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] band,
  input  logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0]   tap,
  output logic signed [COEFF_W-1:0]                             coeff
);

  assign coeff = COEFF_W'(base_coeff(int'(band), int'(tap)));

endmodule

// File: rtl/eq_tap_generator.sv
// Computes each FIR tap as sum over bands of base_coeff * gain, saturates it and
// streams taps 0..NUM_TAPS-1 over a valid/ready handshake.
module eq_tap_generator
  import eq_tap_pkg::*;
#(
  parameter int NUM_BANDS    = DEF_NUM_BANDS,
  parameter int GAIN_W       = DEF_GAIN_W,
  parameter int NUM_TAPS     = DEF_NUM_TAPS,
  parameter int COEFF_W      = DEF_COEFF_W,
  parameter int AUTO_RESTART = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BANDS*GAIN_W-1:0]   eqVal,
  input  logic                          start,
  input  logic                          tap_ready,
  output logic signed [COEFF_W-1:0]     tapcoeff,
  output logic [$clog2(NUM_TAPS)-1:0]   tapnum,
  output logic                          tap_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int EQ_W   = NUM_BANDS * GAIN_W;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int ACC_W  = COEFF_W + GAIN_W + $clog2(NUM_BANDS) + 1;

  state_t                    state, state_nxt;
  logic [EQ_W-1:0]           gain_lat;
  logic [EQ_W-1:0]           shadow;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [ACC_W-1:0]   prod;
  logic [TAP_W-1:0]          tap_cnt;
  logic [BAND_W-1:0]         band_cnt;
  logic [GAIN_W-1:0]         gain_b;
  logic signed [COEFF_W-1:0] base;
  logic                      trigger;
  logic                      last_band;
  logic                      last_tap;

  eq_band_rom #(
    .NUM_BANDS (NUM_BANDS),
    .NUM_TAPS  (NUM_TAPS),
    .COEFF_W   (COEFF_W)
  ) u_rom (
    .band  (band_cnt),
    .tap   (tap_cnt),
    .coeff (base)
  );

  // Gains are unsigned codes, so zero-extend before the signed multiply.
  assign gain_b    = gain_lat[band_cnt*GAIN_W +: GAIN_W];
  assign prod      = ACC_W'(base) * ACC_W'($signed({1'b0, gain_b}));
  assign acc_nxt   = acc + prod;
  assign last_band = (band_cnt == BAND_W'(NUM_BANDS - 1));
  assign last_tap  = (tap_cnt == TAP_W'(NUM_TAPS - 1));
  assign trigger   = start || ((AUTO_RESTART != 0) && (eqVal != shadow));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = ACCUM;
      ACCUM:   if (last_band) state_nxt = OUT;
      OUT:     if (tap_ready) state_nxt = last_tap ? DONE : ACCUM;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tap_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ACCUM:   busy = 1'b1;
      OUT:     begin busy = 1'b1; tap_valid = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Accumulate / output stage: the edge leaving ACCUM folds in the last band and registers the tap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain_lat <= '0;
      shadow   <= '0;
      acc      <= '0;
      tap_cnt  <= '0;
      band_cnt <= '0;
      tapcoeff <= '0;
      tapnum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            gain_lat <= eqVal;
            shadow   <= eqVal;
            acc      <= '0;
            tap_cnt  <= '0;
            band_cnt <= '0;
          end
        end
        ACCUM: begin
          acc      <= acc_nxt;
          band_cnt <= band_cnt + 1'b1;
          if (last_band) begin
            tapcoeff <= COEFF_W'(sat(64'(acc_nxt), COEFF_W));
            tapnum   <= tap_cnt;
            band_cnt <= '0;
          end
        end
        OUT: begin
          if (tap_ready && !last_tap) begin
            tap_cnt  <= tap_cnt + 1'b1;
            acc      <= '0;
            band_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_tap_generator.sv
// Directed bench for eq_tap_generator: default 16-bit instance plus an 8-bit instance for saturation.
module tb_eq_tap_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [7:0]         eqVal;
  logic               start;
  logic               tap_ready;
  logic signed [15:0] tapcoeff;
  logic [3:0]         tapnum;
  logic               tap_valid, busy, done;

  logic [7:0]         eqVal8;
  logic               start8;
  logic               tap_ready8;
  logic signed [7:0]  tapcoeff8;
  logic [3:0]         tapnum8;
  logic               tap_valid8, busy8, done8;

  int n_cmp = 0;
  int n_err = 0;

  eq_tap_generator dut (
    .clk(clk), .reset(reset), .eqVal(eqVal), .start(start), .tap_ready(tap_ready),
    .tapcoeff(tapcoeff), .tapnum(tapnum), .tap_valid(tap_valid), .busy(busy), .done(done)
  );

  eq_tap_generator #(.COEFF_W(8)) dut8 (
    .clk(clk), .reset(reset), .eqVal(eqVal8), .start(start8), .tap_ready(tap_ready8),
    .tapcoeff(tapcoeff8), .tapnum(tapnum8), .tap_valid(tap_valid8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected tap n: gain sum times (n+1), clamped to the positive limit of a w-bit word.
  function automatic longint expv(input int gsum, input int n, input int w);
    longint v, hi;
    v  = longint'(gsum) * longint'(n + 1);
    hi = (longint'(1) <<< (w - 1)) - 1;
    return (v > hi) ? hi : v;
  endfunction

  // Must be called 1 time unit after a rising edge.
  task automatic run16(input logic [7:0] eq_first, input logic [7:0] eq_mid, input bit do_start,
                       input int gsum, input int mode, input bit poke, input string tag);
    int hs, last_hs_cyc, prev_first;
    bit stalled, finished, was_valid;
    logic signed [15:0] hc;
    logic [3:0] hn;
    hs = 0; last_hs_cyc = -100; prev_first = -1;
    stalled = 0; finished = 0; was_valid = 0;
    hc = '0; hn = '0;
    eqVal = eq_first;
    start = do_start;
    tap_ready = 1'b1;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 20) eqVal = eq_mid;
      if (stalled) begin
        check({tag, " stall coeff"}, tapcoeff, hc);
        check({tag, " stall num"}, tapnum, hn);
      end
      if (tap_valid && !was_valid) begin
        if (mode == 0 && prev_first >= 0) check({tag, " period"}, cyc - prev_first, 5);
        prev_first = cyc;
      end
      was_valid = tap_valid;
      if (done) begin
        check({tag, " taps before done"}, hs, 16);
        check({tag, " done after last hs"}, cyc - last_hs_cyc, 1);
        check({tag, " done hold coeff"}, tapcoeff, expv(gsum, 15, 16));
        check({tag, " done hold num"}, tapnum, 15);
        check({tag, " busy in done"}, busy, 0);
        finished = 1;
      end
      if (poke && !finished && (cyc % 7 == 3)) start = 1'b1;
      tap_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (tap_valid && tap_ready) begin
        check({tag, " tapnum"}, tapnum, hs);
        check({tag, " tapcoeff"}, tapcoeff, expv(gsum, hs, 16));
        hs++;
        last_hs_cyc = cyc;
      end
      stalled = tap_valid && !tap_ready;
      hc = tapcoeff;
      hn = tapnum;
    end
    start = 1'b0;
    if (!finished) check({tag, " timeout waiting for done"}, 0, 1);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (busy || done || tap_valid) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int hs8, found, done8_seen;
    reset = 1'b1; eqVal = 8'h00; start = 1'b0; tap_ready = 1'b0;
    eqVal8 = 8'h00; start8 = 1'b0; tap_ready8 = 1'b1;
    @(posedge clk); #1;
    check("rst tapcoeff", tapcoeff, 0);
    check("rst tapnum", tapnum, 0);
    check("rst tap_valid", tap_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    reset = 1'b0;

    run16(8'hF4, 8'hF4, 1'b1, 7, 0, 1'b0, "ready_high");
    idle_check(8, "idle after ready_high");

    run16(8'hF4, 8'hF4, 1'b1, 7, 1, 1'b0, "stall");
    idle_check(8, "idle after stall");

    run16(8'hF4, 8'h55, 1'b1, 7, 0, 1'b0, "auto_first");
    run16(8'h55, 8'h55, 1'b0, 4, 0, 1'b0, "auto_second");
    idle_check(40, "no third run");

    // Abort mid-run during tap 6
    eqVal = 8'hF4; start = 1'b1; tap_ready = 1'b1; found = 0;
    for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tap_valid && tapnum == 4'd6) found = 1;
    end
    check("reach tap 6", found, 1);
    #2 reset = 1'b1;
    #1;
    check("async rst tapcoeff", tapcoeff, 0);
    check("async rst tapnum", tapnum, 0);
    check("async rst tap_valid", tap_valid, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    @(posedge clk); #1;
    check("rst held done", done, 0);
    reset = 1'b0;
    run16(8'hF4, 8'hF4, 1'b1, 7, 0, 1'b0, "after_reset");
    idle_check(8, "idle after after_reset");

    run16(8'h00, 8'h00, 1'b1, 0, 0, 1'b1, "zero_gain");
    idle_check(20, "idle after zero_gain");

    // 8-bit instance: gain sum 12 saturates from tap 10 on
    eqVal8 = 8'hFF; start8 = 1'b1; hs8 = 0; done8_seen = 0;
    for (int cyc = 0; cyc < 300 && done8_seen == 0; cyc++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) done8_seen = 1;
      if (tap_valid8 && tap_ready8) begin
        check("sat8 tapnum", tapnum8, hs8);
        check("sat8 tapcoeff", tapcoeff8, expv(12, hs8, 8));
        hs8++;
      end
    end
    check("sat8 done seen", done8_seen, 1);
    check("sat8 tap count", hs8, 16);
    check("sat8 busy after", busy8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
